pc_target_table: RTL and testbench
==================================

Name: pc_target_table

Overview:
Writable, multi-bank successor to the fixed branch-target lookup. Holds BANKS banks of 2**IDX_W branch-target entries, one bank per program image. The loader fills each bank at boot; software can retarget entries at run time. Fetch/branch logic queries it with a 1-cycle registered lookup that returns either an absolute target or a PC-relative target (CurPC + signed offset, mod 2**PC_W). A bank-clear FSM invalidates a whole bank.

Parameters:
PC_W, 12, program-counter / target width in bits
IDX_W, 4, entry index width; entries per bank = 2**IDX_W
BANKS, 4, number of program banks (>=1); bank select width BK_W = max(1, clog2(BANKS))

Ports:
Clk  in  1  clock, rising edge
Reset_n  in  1  asynchronous active-low reset
WrEn  in  1  write strobe; one entry written per cycle
WrBank  in  BK_W  bank to write
WrIdx  in  IDX_W  entry to write
WrData  in  PC_W  target (absolute) or two's-complement offset (relative)
WrRel  in  1  entry mode stored with the data: 1 = relative, 0 = absolute
ClrReq  in  1  pulse: start invalidating bank ClrBank
ClrBank  in  BK_W  bank to clear
Busy  out  1  high while the clear FSM runs
LkReq  in  1  lookup request
LkBank  in  BK_W  bank to look up
LkIdx  in  IDX_W  entry to look up
CurPC  in  PC_W  PC of the branch, sampled with LkReq
LkReady  out  1  lookup accepted this cycle when LkReq & LkReady
LkValid  out  1  result valid, 1 cycle after acceptance
Hit  out  1  entry was valid (qualified by LkValid)
Target  out  PC_W  resolved target

Behaviour:
- Reset (async, Reset_n=0): all entry valid bits = 0; FSM -> IDLE; Busy=0, LkValid=0, Hit=0, Target=0. Entry data/mode storage is not reset. Reset asserted mid-clear aborts the clear; the bank is fully invalid anyway.
- Storage per entry: PC_W data, 1 mode bit, 1 valid bit.
- Write: when WrEn=1 and state IDLE, at the clock edge store WrData and WrRel and set valid. WrBank >= BANKS: write dropped. WrEn during CLEAR: dropped, no error flag; the writer must check Busy.
- Lookup: LkReady = (state==IDLE). An accepted request registers result; next cycle LkValid=1 for exactly one cycle (back-to-back requests give back-to-back results, throughput 1/cycle).
- Resolution: invalid entry or LkBank >= BANKS -> Hit=0, Target=0. Absolute -> Target = data. Relative -> Target = (CurPC + data) mod 2**PC_W, with data treated as signed PC_W and wrap-around, no saturation.
- Same-cycle write and lookup of the same entry: lookup returns the OLD contents (read-before-write); the new value is visible from the next request.
- Target and Hit hold their last values while LkValid=0.
- Clear FSM states:
  - IDLE: ClrReq=1 with ClrBank < BANKS -> CLEAR, latch bank, counter=0, Busy=1. ClrBank out of range is ignored.
  - CLEAR: clear the valid bit of [bank][counter] each cycle and increment the counter. Exit to IDLE after the last index (2**IDX_W cycles). Busy drops on the cycle the FSM returns to IDLE.
  - ClrReq while in CLEAR is ignored.
- Clear arrival vs lookup: ClrReq and an accepted LkReq in the same IDLE cycle -> the lookup is accepted (it sees pre-clear contents), and the clear starts the same edge.
- A result already in flight when CLEAR begins still completes normally.

Decomposition:
- Shared package: PC_W and IDX_W defaults, a bank-select width function, and a packed entry typedef {valid, rel, data}.
- One natural sub-module, pc_target_resolve: combinational absolute/relative adder with wrap. It is reusable by the branch unit.

Test Plan:
- Reset then lookup bank0 idx3 -> LkValid pulse next cycle, Hit=0, Target=0.
- Write bank1 idx2 absolute 159, then lookup -> Hit=1, Target=159, 1-cycle latency.
- Write bank0 idx5 relative 0xFFB (-5), CurPC=4 -> Target=0xFFF. Write 0x014, CurPC=0xFF0 -> Target=0x004 (wrap).
- Same-cycle write 20 / lookup of an entry holding 7 -> Target=7; the following lookup -> 20.
- Fill bank2, ClrReq bank2 -> Busy high for 16 cycles and LkReady=0 throughout. Afterwards bank2 lookups all miss; bank1 entries are unchanged.
- Assert Reset_n=0 mid-clear and mid-lookup -> outputs 0 immediately, Busy=0, all banks miss after release.

Source files
------------

// File: rtl/pc_target_table_pkg.sv
// Shared types and defaults for the banked branch-target table.
// Reused by the table top, its interface and the target resolver.
package pc_target_table_pkg;

  localparam int unsigned PC_W      = 12;
  localparam int unsigned IDX_W     = 4;
  localparam int unsigned NUM_ENT   = 32'(1) << IDX_W;
  localparam int unsigned BANKS_DEF = 4;

  // Bank-select width; at least one bit even for a single bank.
  function automatic int unsigned bank_sel_w(input int unsigned banks);
    return (banks > 1) ? unsigned'($clog2(banks)) : 1;
  endfunction

  typedef struct packed {
    logic            valid;
    logic            rel;
    logic [PC_W-1:0] data;
  } entry_t;

  typedef enum logic {
    ST_IDLE,
    ST_CLEAR
  } clr_state_e;

endpackage

// File: rtl/pc_target_table_if.sv
// Write / clear / lookup bus of the branch-target table.
interface pc_target_table_if
  import pc_target_table_pkg::*;
#(
  parameter int unsigned BANKS = BANKS_DEF
);

  localparam int unsigned BK_W = bank_sel_w(BANKS);

  logic             WrEn;
  logic [BK_W-1:0]  WrBank;
  logic [IDX_W-1:0] WrIdx;
  logic [PC_W-1:0]  WrData;
  logic             WrRel;
  logic             ClrReq;
  logic [BK_W-1:0]  ClrBank;
  logic             Busy;
  logic             LkReq;
  logic [BK_W-1:0]  LkBank;
  logic [IDX_W-1:0] LkIdx;
  logic [PC_W-1:0]  CurPC;
  logic             LkReady;
  logic             LkValid;
  logic             Hit;
  logic [PC_W-1:0]  Target;

  modport master (
    output WrEn, WrBank, WrIdx, WrData, WrRel, ClrReq, ClrBank,
    output LkReq, LkBank, LkIdx, CurPC,
    input  Busy, LkReady, LkValid, Hit, Target
  );

  modport slave (
    input  WrEn, WrBank, WrIdx, WrData, WrRel, ClrReq, ClrBank,
    input  LkReq, LkBank, LkIdx, CurPC,
    output Busy, LkReady, LkValid, Hit, Target
  );

endinterface

// File: rtl/pc_target_resolve.sv
// Combinational target resolution: absolute data, or PC plus signed offset
// wrapping modulo 2**PC_W. Invalid entries resolve to a miss with target 0.
module pc_target_resolve
  import pc_target_table_pkg::*;
(
  input  entry_t          entry_i,
  input  logic [PC_W-1:0] pc_i,
  output logic            hit_c_o,
  output logic [PC_W-1:0] target_c_o
);

  always_comb begin
    hit_c_o    = entry_i.valid;
    target_c_o = '0;
    if (entry_i.valid) begin
      target_c_o = entry_i.rel ? (pc_i + entry_i.data) : entry_i.data;
    end
  end

endmodule

// File: rtl/pc_target_table.sv
// Multi-bank writable branch-target table with 1-cycle registered lookup
// and a per-bank clear FSM that invalidates one entry per cycle.
module pc_target_table
  import pc_target_table_pkg::*;
#(
  parameter int unsigned BANKS = BANKS_DEF
)(
  input  logic               Clk,
  input  logic               Reset_n,
  pc_target_table_if.slave   bus
);

  localparam int unsigned      BK_W     = bank_sel_w(BANKS);
  localparam logic [IDX_W-1:0] LAST_IDX = '1;

  logic            valid_q [BANKS][NUM_ENT];
  logic [PC_W:0]   mem_q   [BANKS][NUM_ENT];

  clr_state_e       state_q, state_d;
  logic [BK_W-1:0]  clr_bank_q, clr_bank_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;
  logic             busy_q, lk_ready_q, lk_valid_q, hit_q;
  logic [PC_W-1:0]  target_q;

  logic             wr_bank_ok, lk_bank_ok, clr_bank_ok;
  logic             wr_fire, lk_fire;
  entry_t           rd_entry;
  logic             hit_c;
  logic [PC_W-1:0]  target_c;

  // Range checks only exist when BANKS leaves unused bank codes.
  if (BANKS == (32'(1) << BK_W)) begin : g_full_banks
    assign wr_bank_ok  = 1'b1;
    assign lk_bank_ok  = 1'b1;
    assign clr_bank_ok = 1'b1;
  end else begin : g_partial_banks
    assign wr_bank_ok  = (bus.WrBank  < BK_W'(BANKS));
    assign lk_bank_ok  = (bus.LkBank  < BK_W'(BANKS));
    assign clr_bank_ok = (bus.ClrBank < BK_W'(BANKS));
  end

  assign wr_fire = bus.WrEn & wr_bank_ok & (state_q == ST_IDLE);
  assign lk_fire = bus.LkReq & lk_ready_q;

  always_comb begin
    state_d    = state_q;
    clr_bank_d = clr_bank_q;
    cnt_d      = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.ClrReq && clr_bank_ok) begin
          state_d    = ST_CLEAR;
          clr_bank_d = bus.ClrBank;
          cnt_d      = '0;
        end
      end
      ST_CLEAR: begin
        cnt_d = cnt_q + IDX_W'(1);
        if (cnt_q == LAST_IDX) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Read-before-write: lookup sees the array contents before this edge.
  always_comb begin
    rd_entry = '0;
    if (lk_bank_ok) begin
      rd_entry.valid = valid_q[bus.LkBank][bus.LkIdx];
      rd_entry.rel   = mem_q[bus.LkBank][bus.LkIdx][PC_W];
      rd_entry.data  = mem_q[bus.LkBank][bus.LkIdx][PC_W-1:0];
    end
  end

  pc_target_resolve u_resolve (
    .entry_i    (rd_entry),
    .pc_i       (bus.CurPC),
    .hit_c_o    (hit_c),
    .target_c_o (target_c)
  );

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q    <= ST_IDLE;
      clr_bank_q <= '0;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      lk_ready_q <= 1'b1;
      lk_valid_q <= 1'b0;
      hit_q      <= 1'b0;
      target_q   <= '0;
    end else begin
      state_q    <= state_d;
      clr_bank_q <= clr_bank_d;
      cnt_q      <= cnt_d;
      busy_q     <= (state_d == ST_CLEAR);
      lk_ready_q <= (state_d == ST_IDLE);
      lk_valid_q <= lk_fire;
      if (lk_fire) begin
        hit_q    <= hit_c;
        target_q <= target_c;
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int b = 0; b < int'(BANKS); b++) begin
        for (int i = 0; i < int'(NUM_ENT); i++) begin
          valid_q[b][i] <= 1'b0;
        end
      end
    end else begin
      if (wr_fire) begin
        valid_q[bus.WrBank][bus.WrIdx] <= 1'b1;
      end
      if (state_q == ST_CLEAR) begin
        valid_q[clr_bank_q][cnt_q] <= 1'b0;
      end
    end
  end

  // Entry payload carries no reset; the valid bit gates its use.
  always_ff @(posedge Clk) begin
    if (wr_fire) begin
      mem_q[bus.WrBank][bus.WrIdx] <= {bus.WrRel, bus.WrData};
    end
  end

  assign bus.Busy    = busy_q;
  assign bus.LkReady = lk_ready_q;
  assign bus.LkValid = lk_valid_q;
  assign bus.Hit     = hit_q;
  assign bus.Target  = target_q;

endmodule

// File: tb/tb_pc_target_table.sv
// Scoreboard bench for pc_target_table: randomized and directed traffic
// against an array-based reference model of the table.
module tb_pc_target_table;
  import pc_target_table_pkg::*;

  localparam int unsigned TB_BANKS = 3;
  localparam int unsigned BKW      = bank_sel_w(TB_BANKS);
  localparam int          NENT     = 16;
  localparam int          MODV     = 4096;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  pc_target_table_if #(.BANKS(TB_BANKS)) bus ();

  pc_target_table #(.BANKS(TB_BANKS)) dut (
    .Clk     (clk),
    .Reset_n (rst_n),
    .bus     (bus)
  );

  typedef struct {
    bit hit;
    int tgt;
  } exp_t;

  exp_t q[$];
  bit   m_valid [4][NENT];
  bit   m_rel   [4][NENT];
  int   m_data  [4][NENT];
  bit   m_busy;
  int   m_left;
  bit   last_hit;
  int   last_tgt;
  int   tests;
  int   fails;

  bit s_wr, s_wrel, s_clr, s_lk;
  int s_wb, s_wi, s_wd, s_cb, s_lb, s_li, s_pc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t model_lookup(input int b, input int i, input int pc);
    exp_t e;
    int   off;
    e.hit = 1'b0;
    e.tgt = 0;
    if (b < int'(TB_BANKS) && m_valid[b][i]) begin
      e.hit = 1'b1;
      if (m_rel[b][i]) begin
        off   = (m_data[b][i] >= MODV / 2) ? m_data[b][i] - MODV : m_data[b][i];
        e.tgt = ((pc + off) % MODV + MODV) % MODV;
      end else begin
        e.tgt = m_data[b][i];
      end
    end
    return e;
  endfunction

  task automatic model_reset();
    for (int b = 0; b < 4; b++)
      for (int i = 0; i < NENT; i++) m_valid[b][i] = 1'b0;
    q.delete();
    m_busy   = 1'b0;
    m_left   = 0;
    last_hit = 1'b0;
    last_tgt = 0;
  endtask

  // One clock cycle: drive, predict, commit the model at the edge.
  task automatic step();
    exp_t e;
    bit   acc;
    bus.WrEn    = s_wr;
    bus.WrBank  = BKW'(s_wb);
    bus.WrIdx   = IDX_W'(s_wi);
    bus.WrData  = PC_W'(s_wd);
    bus.WrRel   = s_wrel;
    bus.ClrReq  = s_clr;
    bus.ClrBank = BKW'(s_cb);
    bus.LkReq   = s_lk;
    bus.LkBank  = BKW'(s_lb);
    bus.LkIdx   = IDX_W'(s_li);
    bus.CurPC   = PC_W'(s_pc);
    acc = s_lk && !m_busy;
    e   = model_lookup(s_lb, s_li, s_pc);
    @(posedge clk);
    if (acc) q.push_back(e);
    if (!m_busy) begin
      if (s_wr && s_wb < int'(TB_BANKS)) begin
        m_valid[s_wb][s_wi] = 1'b1;
        m_rel[s_wb][s_wi]   = s_wrel;
        m_data[s_wb][s_wi]  = s_wd;
      end
      if (s_clr && s_cb < int'(TB_BANKS)) begin
        for (int i = 0; i < NENT; i++) m_valid[s_cb][i] = 1'b0;
        m_busy = 1'b1;
        m_left = NENT;
      end
    end else begin
      m_left--;
      if (m_left == 0) m_busy = 1'b0;
    end
    #1;
    s_wr  = 1'b0;
    s_clr = 1'b0;
    s_lk  = 1'b0;
  endtask

  task automatic do_write(input int b, input int i, input int d, input bit rel);
    s_wr = 1'b1; s_wb = b; s_wi = i; s_wd = d; s_wrel = rel;
    step();
  endtask

  task automatic do_lookup(input int b, input int i, input int pc);
    s_lk = 1'b1; s_lb = b; s_li = i; s_pc = pc;
    step();
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      check("busy", 32'(bus.Busy), 32'(m_busy));
      check("lkready", 32'(bus.LkReady), 32'(!m_busy));
      if (q.size() > 0) begin
        e = q.pop_front();
        check("lkvalid", 32'(bus.LkValid), 32'd1);
        last_hit = e.hit;
        last_tgt = e.tgt;
      end else begin
        check("lkvalid", 32'(bus.LkValid), 32'd0);
      end
      check("hit", 32'(bus.Hit), 32'(last_hit));
      check("target", 32'(bus.Target), 32'(last_tgt));
    end
  end

  initial begin
    tests = 0;
    fails = 0;
    s_wr = 0; s_wrel = 0; s_clr = 0; s_lk = 0;
    s_wb = 0; s_wi = 0; s_wd = 0; s_cb = 0; s_lb = 0; s_li = 0; s_pc = 0;
    bus.WrEn = 0; bus.WrBank = '0; bus.WrIdx = '0; bus.WrData = '0; bus.WrRel = 0;
    bus.ClrReq = 0; bus.ClrBank = '0; bus.LkReq = 0; bus.LkBank = '0;
    bus.LkIdx = '0; bus.CurPC = '0;
    model_reset();
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("rst_busy", 32'(bus.Busy), 32'd0);
    check("rst_lkvalid", 32'(bus.LkValid), 32'd0);
    check("rst_hit", 32'(bus.Hit), 32'd0);
    check("rst_target", 32'(bus.Target), 32'd0);
    check("rst_lkready", 32'(bus.LkReady), 32'd1);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;

    do_lookup(0, 3, 100);
    do_write(1, 2, 159, 1'b0);
    do_lookup(1, 2, 0);
    do_write(0, 5, 12'hFFB, 1'b1);
    do_lookup(0, 5, 4);
    do_write(0, 5, 12'h014, 1'b1);
    do_lookup(0, 5, 12'hFF0);

    // Same-cycle write and lookup returns the old contents.
    do_write(0, 7, 7, 1'b0);
    s_wr = 1'b1; s_wb = 0; s_wi = 7; s_wd = 20; s_wrel = 1'b0;
    s_lk = 1'b1; s_lb = 0; s_li = 7; s_pc = 0;
    step();
    do_lookup(0, 7, 0);

    // Unused bank code: write dropped, lookup misses, clear ignored.
    do_write(3, 1, 55, 1'b0);
    do_lookup(3, 1, 0);
    s_clr = 1'b1; s_cb = 3;
    step();

    for (int i = 0; i < NENT; i++) do_write(2, i, $urandom_range(0, MODV - 1), 1'($urandom_range(0, 1)));
    for (int i = 0; i < NENT; i++) do_lookup(2, i, $urandom_range(0, MODV - 1));
    s_clr = 1'b1; s_cb = 2;
    step();
    for (int c = 0; c < NENT + 2; c++) begin
      s_lk = 1'b1; s_lb = 2; s_li = c % NENT; s_pc = 0;
      s_wr = 1'b1; s_wb = 2; s_wi = c % NENT; s_wd = 9; s_wrel = 1'b0;
      s_clr = 1'b1; s_cb = 1;
      step();
    end
    for (int i = 0; i < NENT; i++) do_lookup(2, i, 0);
    do_lookup(1, 2, 0);

    // Clear and lookup in the same cycle: lookup sees pre-clear data.
    s_lk = 1'b1; s_lb = 1; s_li = 2; s_pc = 0;
    s_clr = 1'b1; s_cb = 1;
    step();
    for (int c = 0; c < NENT; c++) step();
    do_lookup(1, 2, 0);

    for (int c = 0; c < 1500; c++) begin
      s_wr   = ($urandom_range(0, 2) == 0);
      s_wb   = $urandom_range(0, 3);
      s_wi   = $urandom_range(0, NENT - 1);
      s_wd   = $urandom_range(0, MODV - 1);
      s_wrel = 1'($urandom_range(0, 1));
      s_clr  = ($urandom_range(0, 60) == 0);
      s_cb   = $urandom_range(0, 3);
      s_lk   = 1'($urandom_range(0, 1));
      s_lb   = $urandom_range(0, 3);
      s_li   = $urandom_range(0, NENT - 1);
      s_pc   = $urandom_range(0, MODV - 1);
      step();
    end

    for (int b = 0; b < int'(TB_BANKS); b++)
      for (int i = 0; i < NENT; i++) do_write(b, i, $urandom_range(0, MODV - 1), 1'b0);

    // Reset with a lookup result and a clear both in flight.
    s_lk = 1'b1; s_lb = 0; s_li = 1; s_pc = 0;
    s_clr = 1'b1; s_cb = 0;
    step();
    rst_n = 1'b0;
    model_reset();
    #1;
    check("midrst_lkvalid", 32'(bus.LkValid), 32'd0);
    check("midrst_hit", 32'(bus.Hit), 32'd0);
    check("midrst_target", 32'(bus.Target), 32'd0);
    check("midrst_busy", 32'(bus.Busy), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int b = 0; b < int'(TB_BANKS); b++)
      for (int i = 0; i < NENT; i++) do_lookup(b, i, $urandom_range(0, MODV - 1));

    step();
    step();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
